// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and default parameters for the LED pattern
// sequencer and its prescaler.
//   mode_e : pattern modes selectable over the config handshake
//   dir_e  : bounce direction for the SCAN pattern
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_OFF   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_e;

    // Board defaults: 4 LEDs, 100 ms steps at 33 MHz, 16-level brightness.
    localparam int DEF_NUM_LEDS = 4;
    localparam int DEF_TICK_DIV = 3300000;
    localparam int DEF_PWM_BITS = 4;

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: divides clk by TICK_DIV and emits a registered one-cycle
// tick in the cycle after the divider reaches TICK_DIV-1.
//   i_clk    : system clock
//   i_reset  : synchronous active-high reset
//   i_enable : 1 = divider runs, 0 = divider holds and tick stays low
//   o_tick   : one-cycle step pulse
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic          r_tick;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (i_enable) begin
            r_tick    <= (r_div_cnt == LAST);
            r_div_cnt <= (r_div_cnt == LAST) ? '0 : r_div_cnt + CW'(1);
        end else begin
            // Frozen: the count is held so counting resumes where it left off.
            r_tick    <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: steps an LED pattern (count / scan / blink / off) on each
// prescaler tick and PWM-gates it onto the pins. Mode and duty arrive over a
// valid/ready handshake into a single pending slot that is applied on the
// next tick, so the pattern and brightness only ever change on a step.
//   clk, reset   : system clock, synchronous active-high reset
//   enable       : 1 = prescaler runs, 0 = pattern frozen (PWM keeps running)
//   cfg_valid    : config request valid
//   cfg_ready    : pending slot free
//   cfg_mode     : requested mode
//   cfg_duty     : requested brightness (all-ones = solid on, 0 = off)
//   tick         : one-cycle pulse per pattern step
//   pattern      : current pattern before PWM
//   led          : PWM-gated pattern, one cycle behind pattern
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  mode_e               cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic                tick,
    output logic [NUM_LEDS-1:0] pattern,
    output logic [NUM_LEDS-1:0] led
);

    localparam int MSB = NUM_LEDS - 1;

    logic                w_tick;

    mode_e               r_mode,      w_mode_nxt;
    logic [PWM_BITS-1:0] r_duty,      w_duty_nxt;
    dir_e                r_dir,       w_dir_nxt;
    logic [NUM_LEDS-1:0] r_pattern,   w_pat_nxt;
    logic                r_pend_vld,  w_pend_vld_nxt;
    mode_e               r_pend_mode, w_pend_mode_nxt;
    logic [PWM_BITS-1:0] r_pend_duty, w_pend_duty_nxt;

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [NUM_LEDS-1:0] r_led;
    logic                w_gate;
    logic                w_accept;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_enable (enable),
        .o_tick   (w_tick)
    );

    // Pattern value loaded on the apply tick instead of a step.
    function automatic logic [NUM_LEDS-1:0] mode_init(input mode_e m);
        logic [NUM_LEDS-1:0] v;
        case (m)
            MODE_SCAN:  v = NUM_LEDS'(1);
            MODE_BLINK: v = {NUM_LEDS{1'b1}};
            default:    v = '0;
        endcase
        return v;
    endfunction

    assign w_accept = cfg_valid & ~r_pend_vld;

    always_comb begin
        w_mode_nxt      = r_mode;
        w_duty_nxt      = r_duty;
        w_dir_nxt       = r_dir;
        w_pat_nxt       = r_pattern;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_mode_nxt = r_pend_mode;
        w_pend_duty_nxt = r_pend_duty;

        if (w_tick) begin
            if (r_pend_vld) begin
                // Only a slot captured before this tick is applied; a capture
                // in the tick cycle itself is still empty here and waits.
                w_mode_nxt     = r_pend_mode;
                w_duty_nxt     = r_pend_duty;
                w_pat_nxt      = mode_init(r_pend_mode);
                w_dir_nxt      = DIR_UP;
                w_pend_vld_nxt = 1'b0;
            end else begin
                case (r_mode)
                    MODE_COUNT: w_pat_nxt = r_pattern + NUM_LEDS'(1);
                    MODE_SCAN: begin
                        // Reverse at the end bits without repeating them.
                        if (r_dir == DIR_UP) begin
                            if (r_pattern[MSB]) begin
                                w_dir_nxt = DIR_DOWN;
                                w_pat_nxt = r_pattern >> 1;
                            end else begin
                                w_pat_nxt = r_pattern << 1;
                            end
                        end else begin
                            if (r_pattern[0]) begin
                                w_dir_nxt = DIR_UP;
                                w_pat_nxt = r_pattern << 1;
                            end else begin
                                w_pat_nxt = r_pattern >> 1;
                            end
                        end
                    end
                    MODE_BLINK: w_pat_nxt = ~r_pattern;
                    default:    w_pat_nxt = '0;
                endcase
            end
        end

        // Capture and apply never coincide: capture needs an empty slot,
        // apply needs a full one.
        if (w_accept) begin
            w_pend_vld_nxt  = 1'b1;
            w_pend_mode_nxt = cfg_mode;
            w_pend_duty_nxt = cfg_duty;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= MODE_COUNT;
            r_duty      <= {PWM_BITS{1'b1}};
            r_dir       <= DIR_UP;
            r_pattern   <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_mode <= MODE_COUNT;
            r_pend_duty <= '0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_duty      <= w_duty_nxt;
            r_dir       <= w_dir_nxt;
            r_pattern   <= w_pat_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_mode <= w_pend_mode_nxt;
            r_pend_duty <= w_pend_duty_nxt;
        end
    end

    // Full duty bypasses the compare so all-ones means solid on rather than
    // on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
    assign w_gate = (r_duty == {PWM_BITS{1'b1}}) || (r_pwm_cnt < r_duty);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= '0;
            r_led     <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            r_led     <= r_pattern & {NUM_LEDS{w_gate}};
        end
    end

    assign cfg_ready = ~r_pend_vld;
    assign tick      = w_tick;
    assign pattern   = r_pattern;
    assign led       = r_led;

endmodule

// File: tb/tb_led_pattern_seq.sv
module tb_led_pattern_seq;
    import led_seq_pkg::*;

    localparam int NL = 4;
    localparam int TD = 4;
    localparam int PB = 4;
    localparam int PMAX = (1 << PB) - 1;
    localparam int LMASK = (1 << NL) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          cfg_valid;
    logic          cfg_ready;
    mode_e         cfg_mode;
    logic [PB-1:0] cfg_duty;
    logic          tick;
    logic [NL-1:0] pattern;
    logic [NL-1:0] led;

    int total = 0;
    int bad   = 0;

    led_pattern_seq #(.NUM_LEDS(NL), .TICK_DIV(TD), .PWM_BITS(PB)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
        .tick(tick), .pattern(pattern), .led(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (state as seen during a cycle) ----------
    int    m_div, m_pwm, m_pat, m_pos, m_duty, m_pduty, m_led;
    bit    m_tick, m_pend, m_up, m_rdy_old, m_nt;
    mode_e m_mode, m_pmode;

    always @(posedge clk) begin
        if (reset) begin
            m_div = 0; m_tick = 0; m_pwm = 0; m_led = 0; m_pat = 0;
            m_mode = MODE_COUNT; m_duty = PMAX; m_pend = 0; m_pos = 0; m_up = 1;
        end else begin
            m_led = (m_duty == PMAX || m_pwm < m_duty) ? m_pat : 0;
            m_pwm = (m_pwm + 1) % (PMAX + 1);
            m_rdy_old = !m_pend;
            if (m_tick) begin
                if (m_pend) begin
                    m_pend = 0; m_mode = m_pmode; m_duty = m_pduty;
                    m_pos = 0; m_up = 1;
                    case (m_mode)
                        MODE_SCAN:  m_pat = 1;
                        MODE_BLINK: m_pat = LMASK;
                        default:    m_pat = 0;
                    endcase
                end else begin
                    case (m_mode)
                        MODE_COUNT: m_pat = (m_pat + 1) % (LMASK + 1);
                        MODE_SCAN: begin
                            if (m_up) begin
                                if (m_pos == NL - 1) begin m_up = 0; m_pos--; end
                                else m_pos++;
                            end else begin
                                if (m_pos == 0) begin m_up = 1; m_pos++; end
                                else m_pos--;
                            end
                            m_pat = 1 << m_pos;
                        end
                        MODE_BLINK: m_pat = m_pat ^ LMASK;
                        default:    m_pat = 0;
                    endcase
                end
            end
            if (m_rdy_old && cfg_valid) begin
                m_pend = 1; m_pmode = cfg_mode; m_pduty = int'(cfg_duty);
            end
            m_nt = enable && (m_div == TD - 1);
            if (enable) m_div = (m_div + 1) % TD;
            m_tick = m_nt;
        end
    end

    always @(negedge clk) begin
        chk("m_tick", int'(tick), int'(m_tick));
        chk("m_pattern", int'(pattern), m_pat);
        chk("m_led", int'(led), m_led);
        chk("m_cfg_ready", int'(cfg_ready), int'(!m_pend));
    end

    // ---------------- helpers ----------------
    // Wait for a tick, then one more negedge so the step is visible.
    task automatic next_step();
        int k = 0;
        while (tick !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        chk("tick_wait", int'(tick), 1);
        @(negedge clk);
    endtask

    task automatic send_cfg(input mode_e m, input logic [PB-1:0] d);
        int k = 0;
        while (cfg_ready !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        chk("cfg_ready_wait", int'(cfg_ready), 1);
        cfg_valid = 1'b1; cfg_mode = m; cfg_duty = d;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("cfg_ready_low", int'(cfg_ready), 0);
    endtask

    typedef struct {
        mode_e         mode;
        logic [PB-1:0] duty;
        int            e0, e1, e2;
    } vec_t;

    vec_t vecs[5];
    int   scan_tail[5];

    initial begin
        int k, ons;

        vecs[0] = '{MODE_SCAN,  4'd15, 1,  2, 4};
        vecs[1] = '{MODE_BLINK, 4'd9,  15, 0, 15};
        vecs[2] = '{MODE_OFF,   4'd15, 0,  0, 0};
        vecs[3] = '{MODE_COUNT, 4'd3,  0,  1, 2};
        vecs[4] = '{MODE_SCAN,  4'd15, 1,  2, 4};
        scan_tail = '{8, 4, 2, 1, 2};

        reset = 1'b1; enable = 1'b1; cfg_valid = 1'b0;
        cfg_mode = MODE_COUNT; cfg_duty = '0;

        // Reset held 20 cycles.
        repeat (20) @(negedge clk);
        chk("rst_led", int'(led), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_pattern", int'(pattern), 0);
        chk("rst_tick", int'(tick), 0);
        reset = 1'b0;

        // First tick TICK_DIV cycles after release, one cycle wide.
        k = 0;
        do begin @(negedge clk); k++; end while (tick !== 1'b1 && k < 10);
        chk("first_tick_lat", k, TD);
        @(negedge clk);
        chk("tick_width", int'(tick), 0);
        chk("count_1", int'(pattern), 1);
        for (int i = 2; i <= 16; i++) begin
            next_step();
            chk("count_seq", int'(pattern), i % 16);
        end

        // Freeze mid-COUNT at 5.
        for (int i = 1; i <= 5; i++) next_step();
        chk("count_5", int'(pattern), 5);
        enable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("frz_tick", int'(tick), 0);
            chk("frz_pattern", int'(pattern), 5);
        end
        enable = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (tick !== 1'b1 && k < 10);
        chk("resume_lat", k, TD - 1);
        @(negedge clk);
        chk("resume_pat", int'(pattern), 6);

        // Table of config vectors: pattern on the apply tick and two steps on.
        foreach (vecs[i]) begin
            send_cfg(vecs[i].mode, vecs[i].duty);
            next_step();
            chk("vec_apply", int'(pattern), vecs[i].e0);
            chk("vec_ready_back", int'(cfg_ready), 1);
            next_step();
            chk("vec_step1", int'(pattern), vecs[i].e1);
            next_step();
            chk("vec_step2", int'(pattern), vecs[i].e2);
        end
        foreach (scan_tail[i]) begin
            next_step();
            chk("scan_bounce", int'(pattern), scan_tail[i]);
        end

        // BLINK duty=4, frozen on 1111: exactly 4 lit cycles per 16.
        send_cfg(MODE_BLINK, 4'd4);
        next_step();
        chk("blink_on", int'(pattern), 15);
        enable = 1'b0;
        @(negedge clk);
        ons = 0;
        repeat (16) begin
            @(negedge clk);
            if (led == 4'hF) ons++;
            else chk("blink_led_off", int'(led), 0);
        end
        chk("duty4_on_cycles", ons, 4);
        enable = 1'b1;

        // duty=0 keeps led dark.
        send_cfg(MODE_BLINK, 4'd0);
        next_step();
        @(negedge clk);
        ons = 0;
        repeat (16) begin @(negedge clk); if (led != 0) ons++; end
        chk("duty0_dark", ons, 0);

        // Pending OFF, ignored SCAN request, then reset before the apply tick.
        next_step();
        send_cfg(MODE_OFF, 4'd15);
        cfg_valid = 1'b1; cfg_mode = MODE_SCAN;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("busy_ready", int'(cfg_ready), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst2_ready", int'(cfg_ready), 1);
        chk("rst2_pattern", int'(pattern), 0);
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            next_step();
            chk("post_rst_count", int'(pattern), i);
        end

        // Random traffic against the model.
        repeat (800) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 99) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_mode  = mode_e'($urandom_range(0, 3));
            cfg_duty  = PB'($urandom_range(0, PMAX));
        end
        reset = 1'b0; cfg_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Downstream LED stage for the board blinky designs. It generates an LED pattern on a slow prescaled tick and applies PWM brightness before the pins.
- Replaces free-running counter LEDs with software- or testbench-selectable patterns: count, scan, blink and off.
- Mode and duty changes arrive over a valid/ready config handshake. They take effect only on tick boundaries, so the LEDs never glitch mid-step.

Parameters:
- NUM_LEDS, 4, number of LED outputs.
- TICK_DIV, 3300000, clk cycles per pattern step (100 ms at 33 MHz); must be >= 2.
- PWM_BITS, 4, PWM counter and duty width.

Ports:
- clk  in  1  system clock (33 MHz on board).
- reset  in  1  synchronous reset, active-high; has priority over all other inputs.
- enable  in  1  1 = prescaler runs; 0 = prescaler and pattern freeze.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config slot free.
- cfg_mode  in  2  requested mode (led_seq_pkg::mode_e).
- cfg_duty  in  PWM_BITS  requested brightness.
- tick  out  1  one-cycle pulse at each pattern step.
- pattern  out  NUM_LEDS  current pattern, before PWM.
- led  out  NUM_LEDS  PWM-gated pattern to the pins.

Behaviour:
- Reset values:
  - div_cnt=0, pwm_cnt=0, tick=0.
  - active mode=COUNT, active duty=all-ones.
  - pattern=0, dir=UP, led=0.
  - pending slot empty, cfg_ready=1.
  - Any pending config is discarded on reset.
- Prescaler:
  - While enable=1, div_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 in the cycle after div_cnt==TICK_DIV-1 (registered).
  - First tick occurs TICK_DIV cycles after reset release with enable high.
  - While enable=0, div_cnt holds, tick=0 and pattern holds. On re-enable, counting resumes from the held value.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready; mode and duty are captured into a single pending slot.
  - cfg_ready=0 from the next cycle until the pending slot is applied.
  - The pending slot is applied on the next tick after capture. A capture in the same cycle as a tick waits for the following tick.
  - cfg_ready returns to 1 in the cycle after apply.
  - cfg_valid while cfg_ready=0 is ignored; the requester must hold cfg_valid.
- Apply: on the apply tick, the active mode and duty load from the pending slot, and pattern loads the mode's init value instead of stepping:
  - COUNT: 0.
  - SCAN: one-hot bit0, dir=UP.
  - BLINK: all-ones.
  - OFF: 0.
- Step on every other tick:
  - COUNT: pattern+1, mod 2^NUM_LEDS.
  - SCAN: bounce one-hot.
    - UP shifts left; at the MSB, dir flips to DOWN and the pattern shifts right.
    - DOWN mirrors this at bit0.
    - No endpoint is repeated: 0001,0010,0100,1000,0100,0010,0001,0010...
  - BLINK: pattern = ~pattern.
  - OFF: pattern stays 0.
- PWM:
  - pwm_cnt increments every cycle regardless of enable and wraps at 2^PWM_BITS.
  - gate = (duty==all-ones) ? 1 : (pwm_cnt < duty).
  - led <= pattern & {NUM_LEDS{gate}}, so led lags pattern and pwm_cnt by one cycle.
  - duty=0 keeps led at 0. duty=all-ones gives solid on.
- A duty change takes effect only with its apply tick, never mid-period outside a tick.

Decomposition:
- led_seq_pkg contents:
  - typedef enum logic [1:0] mode_e {MODE_COUNT=0, MODE_SCAN=1, MODE_BLINK=2, MODE_OFF=3}.
  - typedef enum logic {DIR_UP, DIR_DOWN} dir_e.
  - Default-parameter localparams.
- Sub-module: led_tick_gen (TICK_DIV prescaler with enable and tick output). It is reusable by other board designs.
- The config slot, pattern FSM and PWM stay in led_pattern_seq.

Test Plan (TICK_DIV=4, PWM_BITS=4, NUM_LEDS=4, 33 MHz clk):
- Reset held 20 cycles, then released with enable=1 -> led=0, cfg_ready=1, pattern=0 during reset; first tick pulses 4 cycles after release, one cycle wide, then every 4 cycles.
- Default COUNT, no config -> pattern 1,2,3,...,15,0 on successive ticks; led==pattern delayed by one cycle, every cycle.
- Config SCAN (duty=15) -> cfg_ready low until the next tick; on that tick pattern=0001; following ticks give 0010,0100,1000,0100,0010,0001.
- Config BLINK, duty=4 -> pattern alternates 1111/0000 per tick; while pattern=1111, led=1111 for exactly 4 of every 16 cycles. Config duty=0 -> led constant 0.
- enable=0 for 10 cycles mid-COUNT at pattern=5 -> no tick and pattern stays 5; after re-enable, the next tick arrives after the remaining div_cnt cycles and pattern=6.
- Issue cfg OFF, then cfg_valid SCAN while cfg_ready=0 -> second request not accepted. Assert reset before the tick -> pending slot cleared; after release, mode=COUNT and pattern counts from 0.
